// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// over several cycles, with per-access memory wait states, optional addi/j
// decode and a pulse for unsupported opcodes.
module multicycle_control #(
  parameter int unsigned MEM_LATENCY = 0,
  parameter bit          EN_ADDI     = 1'b1,
  parameter bit          EN_JUMP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] operation,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       regdst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur_state;
  state_t     next_state;
  logic [3:0] wait_cnt;
  logic [3:0] next_cnt;
  logic       last_wait;
  logic       op_legal;

  assign last_wait = (wait_cnt == 4'(MEM_LATENCY));
  assign state     = cur_state;

  // Opcode legality, honouring the optional addi/j decode.
  always_comb begin
    op_legal = 1'b0;
    case (operation)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
      OP_ADDI:                        op_legal = EN_ADDI;
      OP_J:                           op_legal = EN_JUMP;
      default:                        op_legal = 1'b0;
    endcase
  end

  // State and wait-counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= next_cnt;
    end
  end

  // Next-state logic; memory states hold until the wait count expires and
  // the counter is zeroed whenever the state is left.
  always_comb begin
    next_state = S_FETCH;
    next_cnt   = '0;
    case (cur_state)
      S_FETCH: begin
        if (last_wait) next_state = S_DECODE;
        else begin
          next_state = S_FETCH;
          next_cnt   = wait_cnt + 4'd1;
        end
      end
      S_DECODE: begin
        case (operation)
          OP_RTYPE:      next_state = S_EXEC;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_ADDI:       next_state = EN_ADDI ? S_ADDIEX : S_FETCH;
          OP_J:          next_state = EN_JUMP ? S_JUMP : S_FETCH;
          default:       next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (operation == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (last_wait) next_state = S_MEMWB;
        else begin
          next_state = S_MEMRD;
          next_cnt   = wait_cnt + 4'd1;
        end
      end
      S_MEMWR: begin
        if (last_wait) next_state = S_FETCH;
        else begin
          next_state = S_MEMWR;
          next_cnt   = wait_cnt + 4'd1;
        end
      end
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // Moore output decode; write enables and pulses are gated off during reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    regdst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = last_wait;
        PCWrite = last_wait;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~op_legal;
        instr_done = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = last_wait;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (L=0 with addi/j, L=2 without)
// compared cycle by cycle against per-instruction expected traces built
// from the instruction phase lists.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op0, op1;
  logic [21:0] o0, o1;

  logic       pcw0, pcwc0, iord0, mrd0, mwr0, m2r0, irw0, asa0, rw0, rd0;
  logic [1:0] pcs0, asb0, aop0;
  logic [3:0] st0;
  logic       done0, ill0;
  logic       pcw1, pcwc1, iord1, mrd1, mwr1, m2r1, irw1, asa1, rw1, rd1;
  logic [1:0] pcs1, asb1, aop1;
  logic [3:0] st1;
  logic       done1, ill1;

  int checks;
  int errors;

  int unsigned lat [2];
  bit          en_addi [2];
  bit          en_jump [2];

  logic [21:0] q0[$];
  logic [21:0] q1[$];
  logic [5:0]  f0[$];
  logic [5:0]  f1[$];
  logic [21:0] cur [2];

  multicycle_control #(.MEM_LATENCY(0), .EN_ADDI(1'b1), .EN_JUMP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .operation(op0),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mrd0),
    .MemWrite(mwr0), .MemtoReg(m2r0), .IRWrite(irw0), .ALUSrcA(asa0),
    .RegWrite(rw0), .regdst(rd0), .PCSource(pcs0), .ALUSrcB(asb0),
    .ALUop(aop0), .state(st0), .instr_done(done0), .illegal_op(ill0)
  );

  multicycle_control #(.MEM_LATENCY(2), .EN_ADDI(1'b0), .EN_JUMP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .operation(op1),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1),
    .MemWrite(mwr1), .MemtoReg(m2r1), .IRWrite(irw1), .ALUSrcA(asa1),
    .RegWrite(rw1), .regdst(rd1), .PCSource(pcs1), .ALUSrcB(asb1),
    .ALUop(aop1), .state(st1), .instr_done(done1), .illegal_op(ill1)
  );

  assign o0 = {pcw0, pcwc0, iord0, mrd0, mwr0, m2r0, irw0, asa0, rw0, rd0,
               pcs0, asb0, aop0, done0, ill0, st0};
  assign o1 = {pcw1, pcwc1, iord1, mrd1, mwr1, m2r1, irw1, asa1, rw1, rd1,
               pcs1, asb1, aop1, done1, ill1, st1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for one cycle of a phase.
  function automatic logic [21:0] word(input int ph, input bit last, input bit illegal);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (ph)
      0:  begin mrd = 1; asb = 2'b01; irw = last; pcw = last; end
      1:  begin asb = 2'b11; ill = illegal; done = illegal; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; iord = 1; done = last; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; done = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop,
            done, ill, 4'(ph)};
  endfunction

  // What the outputs look like while reset is held low.
  function automatic logic [21:0] rst_mask(input logic [21:0] w);
    logic [21:0] m;
    m = w;
    m[21] = 1'b0; m[20] = 1'b0; m[18] = 1'b0; m[17] = 1'b0;
    m[15] = 1'b0; m[13] = 1'b0; m[5]  = 1'b0; m[4]  = 1'b0;
    return m;
  endfunction

  task automatic push(input int d, input logic [21:0] w);
    if (d == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic push_ph(input int d, input int ph, input bit waited, input bit illegal);
    int unsigned n;
    n = waited ? lat[d] + 1 : 1;
    for (int unsigned i = 0; i < n; i++) push(d, word(ph, i == n - 1, illegal));
  endtask

  // Choose the next opcode for a DUT and append its whole cycle trace.
  task automatic gen_instr(input int d);
    logic [5:0] opc;
    int unsigned r;
    if (d == 0 && f0.size() > 0)      opc = f0.pop_front();
    else if (d == 1 && f1.size() > 0) opc = f1.pop_front();
    else begin
      r = $urandom_range(0, 7);
      case (r)
        0: opc = 6'b000000;
        1: opc = 6'b100011;
        2: opc = 6'b101011;
        3: opc = 6'b000100;
        4: opc = 6'b001000;
        5: opc = 6'b000010;
        default: opc = 6'($urandom);
      endcase
    end
    if (d == 0) op0 = opc; else op1 = opc;
    push_ph(d, 0, 1, 0);
    if (opc == 6'b000000) begin
      push_ph(d, 1, 0, 0); push_ph(d, 6, 0, 0); push_ph(d, 7, 0, 0);
    end else if (opc == 6'b100011) begin
      push_ph(d, 1, 0, 0); push_ph(d, 2, 0, 0); push_ph(d, 3, 1, 0); push_ph(d, 4, 0, 0);
    end else if (opc == 6'b101011) begin
      push_ph(d, 1, 0, 0); push_ph(d, 2, 0, 0); push_ph(d, 5, 1, 0);
    end else if (opc == 6'b000100) begin
      push_ph(d, 1, 0, 0); push_ph(d, 8, 0, 0);
    end else if (opc == 6'b001000 && en_addi[d]) begin
      push_ph(d, 1, 0, 0); push_ph(d, 10, 0, 0); push_ph(d, 11, 0, 0);
    end else if (opc == 6'b000010 && en_jump[d]) begin
      push_ph(d, 1, 0, 0); push_ph(d, 9, 0, 0);
    end else begin
      push_ph(d, 1, 0, 1);
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [21:0] exp);
    logic [21:0] obs;
    obs = (d == 0) ? o0 : o1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %h expected %h (time %0t)", tag, d, obs, exp, $time);
    end
  endtask

  task automatic check_now();
    for (int d = 0; d < 2; d++) begin
      if (d == 0 && q0.size() == 0) gen_instr(0);
      if (d == 1 && q1.size() == 0) gen_instr(1);
      cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
      #0;
      chk("trace", d, cur[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic reset_seq(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("reset", 0, rst_mask(word(0, 0, 0)));
      chk("reset", 1, rst_mask(word(0, 0, 0)));
    end
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_now();
  endtask

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    op0 = '0;
    op1 = '0;
    lat[0] = 0; en_addi[0] = 1'b1; en_jump[0] = 1'b1;
    lat[1] = 2; en_addi[1] = 1'b0; en_jump[1] = 1'b0;

    // Directed opening: lw, sw, R-type, beq, bad opcode, addi, j on both.
    f0 = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b111111, 6'b001000, 6'b000010};
    f1 = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b111111, 6'b001000, 6'b000010};

    reset_seq(2);
    repeat (400) step();

    // Abort a load in MEMRD with reset.
    reset_seq(1);
    f0.push_back(6'b100011);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (cur[0][3:0] == 4'd3) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL memrd_reach: observed %0d expected %0d", found, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("reset_mid", 0, rst_mask(cur[0]));
    chk("reset_mid", 1, rst_mask(cur[1]));
    reset_seq(2);
    repeat (200) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
